mm_host_sequencer: RTL and testbench
====================================

MM_HOST_SEQUENCER -- requirements
Module: mm_host_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, config-write command FIFO entries (power of two).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_valid  input  1  config word offered.
REQ-005 cfg_data  input  32  config word for register 0x00.
REQ-006 cfg_ready  output  1  FIFO not full; push when cfg_valid && cfg_ready.
REQ-007 poll_period  input  20  cycles between automatic status polls; 0 disables auto-poll.
REQ-008 poll_now  input  1  one-cycle request for an immediate poll.
REQ-009 err_clr  input  1  clears cfg_mismatch.
REQ-010 mm_write_en  output  1  write strobe to register slave.
REQ-011 mm_read_en  output  1  read strobe to register slave.
REQ-012 mm_addr  output  8  register address.
REQ-013 mm_wdata  output  32  write data.
REQ-014 mm_rdata  input  32  read data, valid the cycle after mm_read_en.
REQ-015 active_channel  output  2  rdata[1:0] of last 0x01 read.
REQ-016 signal_present  output  4  rdata[5:2] of last 0x01 read.
REQ-017 error_counts  output  32  last 0x02 read; ch3 in [31:24] down to ch0 in [7:0].
REQ-018 status_valid  output  1  one-cycle pulse; status outputs updated.
REQ-019 cfg_done  output  1  one-cycle pulse; write plus readback completed.
REQ-020 cfg_mismatch  output  1  sticky; readback differed from written word.
REQ-021 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-022 FSM states: IDLE, WR, RB_REQ, RB_CAP, ST_REQ, ST_CAP, ER_REQ, ER_CAP.
REQ-023 IDLE: FIFO non-empty -> WR (pop head into wdata register); else poll_pending -> ST_REQ; else stay.
REQ-024 Config writes have priority over polls; a poll pending during a write runs after the FIFO drains.
REQ-025 WR -> RB_REQ -> RB_CAP -> IDLE; ST_REQ -> ST_CAP -> ER_REQ -> ER_CAP -> IDLE; one cycle each.
REQ-026 WR: mm_write_en=1, mm_addr=0x00, mm_wdata=popped word.
REQ-027 RB_REQ: mm_read_en=1, addr 0x00; ST_REQ: mm_read_en=1, addr 0x01; ER_REQ: mm_read_en=1, addr 0x02.
REQ-028 All other states: both strobes 0, mm_addr=0x00, mm_wdata=0; strobes never both high.
REQ-029 RB_CAP: compare mm_rdata to written word; cfg_done=1 the following cycle; mismatch sets cfg_mismatch on the same edge.
REQ-030 err_clr clears cfg_mismatch; simultaneous set and err_clr -> set wins.
REQ-031 ST_CAP edge captures active_channel/signal_present; ER_CAP edge captures error_counts; status_valid=1 the following cycle.
REQ-032 Latency: cfg_valid accepted in cycle T, FIFO empty, FSM IDLE -> mm_write_en in T+2, readback strobe T+3, cfg_done T+5.
REQ-033 Poll timer: free-running 20-bit counter; when poll_period!=0 and counter >= poll_period-1, set poll_pending and zero counter; poll_period=0 holds counter at 0.
REQ-034 poll_now sets poll_pending; poll_pending clears on entry to ST_REQ; a request arriving during ST_REQ..ER_CAP is kept for the next poll; multiple requests coalesce.
REQ-035 FIFO full: cfg_ready=0, cfg_valid ignored; push and pop in the same cycle are allowed when not full; pointers wrap modulo FIFO_DEPTH.
REQ-036 FIFO preserves order; every accepted word is written exactly once.

Reset
REQ-037 rst_n low: FSM=IDLE, FIFO empty, counter=0, poll_pending=0, all outputs 0 except cfg_ready=1; takes effect immediately, including mid-transaction (strobes drop without waiting for clk).
REQ-038 After release, first action occurs no earlier than the second rising edge.

Verification
REQ-039 Single write: cfg_data=0x000FA5B1 in cycle T -> write strobe addr 0x00 in T+2, read strobe T+3, mm_rdata=0x000FA5B1 -> cfg_done in T+5, cfg_mismatch=0.
REQ-040 Mismatch: slave returns 0x00000000 for a written 0x12345678 -> cfg_mismatch=1 and stays 1 until err_clr; err_clr and a new mismatch in the same cycle -> stays 1.
REQ-041 FIFO full: 5 back-to-back cfg_valid with FSM busy -> cfg_ready=0 after 4 accepted words; exactly 4 writes issued in order.
REQ-042 Auto-poll: poll_period=10 -> ST_REQ every 10 cycles; slave returns 0x00000036 then 0x04030201 -> active_channel=2, signal_present=0xD, error_counts=0x04030201, one status_valid pulse.
REQ-043 Priority: poll_now and cfg_valid in the same cycle -> write and readback complete first, then the poll.
REQ-044 Reset during RB_REQ -> mm_read_en falls asynchronously; FIFO empty; no cfg_done pulse.

Source files
------------

// File: rtl/mm_host_sequencer.sv
// Host-side sequencer for a memory-mapped register slave: queues config writes,
// reads each one back, and runs periodic or on-demand status/error polls.
module mm_host_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   input  logic [31:0] cfg_data,
   output logic        cfg_ready,
   input  logic [19:0] poll_period,
   input  logic        poll_now,
   input  logic        err_clr,
   output logic        mm_write_en,
   output logic        mm_read_en,
   output logic [7:0]  mm_addr,
   output logic [31:0] mm_wdata,
   input  logic [31:0] mm_rdata,
   output logic [1:0]  active_channel,
   output logic [3:0]  signal_present,
   output logic [31:0] error_counts,
   output logic        status_valid,
   output logic        cfg_done,
   output logic        cfg_mismatch,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WR     = 3'd1;
   localparam logic [2:0] RB_REQ = 3'd2;
   localparam logic [2:0] RB_CAP = 3'd3;
   localparam logic [2:0] ST_REQ = 3'd4;
   localparam logic [2:0] ST_CAP = 3'd5;
   localparam logic [2:0] ER_REQ = 3'd6;
   localparam logic [2:0] ER_CAP = 3'd7;

   logic [2:0]  state_reg, state_next;
   logic [31:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_reg, rd_ptr_reg;
   logic [31:0] wdata_reg;
   logic [19:0] poll_cnt_reg;
   logic        poll_pending_reg;
   logic        fifo_empty, fifo_full, push, pop, poll_tick, start_poll;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign cfg_ready  = !fifo_full;
   assign push       = cfg_valid && !fifo_full;
   assign pop        = (state_reg == IDLE) && !fifo_empty;
   assign start_poll = (state_reg == IDLE) && fifo_empty && poll_pending_reg;
   assign poll_tick  = (poll_period != 20'd0) && (poll_cnt_reg >= poll_period - 20'd1);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= cfg_data;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (!fifo_empty) state_next = WR;
                  else if (poll_pending_reg) state_next = ST_REQ;
         WR:      state_next = RB_REQ;
         RB_REQ:  state_next = RB_CAP;
         RB_CAP:  state_next = IDLE;
         ST_REQ:  state_next = ST_CAP;
         ST_CAP:  state_next = ER_REQ;
         ER_REQ:  state_next = ER_CAP;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         wdata_reg        <= '0;
         poll_cnt_reg     <= '0;
         poll_pending_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            wdata_reg  <= fifo_mem[rd_ptr_reg[AW-1:0]];
         end
         if (poll_period == 20'd0 || poll_tick) poll_cnt_reg <= '0;
         else                                   poll_cnt_reg <= poll_cnt_reg + 20'd1;
         // A new request in the same cycle as poll start is kept for the next poll.
         if (poll_tick || poll_now) poll_pending_reg <= 1'b1;
         else if (start_poll)       poll_pending_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_done       <= 1'b0;
         cfg_mismatch   <= 1'b0;
         status_valid   <= 1'b0;
         active_channel <= '0;
         signal_present <= '0;
         error_counts   <= '0;
      end else begin
         cfg_done     <= (state_reg == RB_CAP);
         status_valid <= (state_reg == ER_CAP);
         if (state_reg == RB_CAP && mm_rdata != wdata_reg) cfg_mismatch <= 1'b1;
         else if (err_clr)                                 cfg_mismatch <= 1'b0;
         if (state_reg == ST_CAP) begin
            active_channel <= mm_rdata[1:0];
            signal_present <= mm_rdata[5:2];
         end
         if (state_reg == ER_CAP) error_counts <= mm_rdata;
      end
   end

   // Bus outputs decode straight from state so reset drops strobes immediately.
   always_comb begin
      mm_write_en = (state_reg == WR);
      mm_read_en  = (state_reg == RB_REQ) || (state_reg == ST_REQ) || (state_reg == ER_REQ);
      mm_addr     = 8'h00;
      if (state_reg == ST_REQ) mm_addr = 8'h01;
      if (state_reg == ER_REQ) mm_addr = 8'h02;
      mm_wdata    = (state_reg == WR) ? wdata_reg : 32'h0;
   end

   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Scoreboard bench for mm_host_sequencer: a register-slave model answers reads,
// expected writes and status results are queued and checked as the DUT produces them.
module tb_mm_host_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic [31:0] cfg_data;
   logic        cfg_ready;
   logic [19:0] poll_period;
   logic        poll_now;
   logic        err_clr;
   logic        mm_write_en;
   logic        mm_read_en;
   logic [7:0]  mm_addr;
   logic [31:0] mm_wdata;
   logic [31:0] mm_rdata = 32'h0;
   logic [1:0]  active_channel;
   logic [3:0]  signal_present;
   logic [31:0] error_counts;
   logic        status_valid;
   logic        cfg_done;
   logic        cfg_mismatch;
   logic        busy;

   always #5 clk = ~clk;

   mm_host_sequencer #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .poll_period(poll_period), .poll_now(poll_now),
      .err_clr(err_clr), .mm_write_en(mm_write_en), .mm_read_en(mm_read_en),
      .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
      .active_channel(active_channel), .signal_present(signal_present),
      .error_counts(error_counts), .status_valid(status_valid),
      .cfg_done(cfg_done), .cfg_mismatch(cfg_mismatch), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   logic [31:0] exp_wr_q [$];
   logic [63:0] exp_st_q [$];
   logic [31:0] slv_reg0 = 32'h0;
   logic [31:0] slv_st   = 32'h0;
   logic [31:0] slv_er   = 32'h0;
   logic        corrupt  = 1'b0;
   int cyc = 0, last_wr_cyc = 0, last_rd0_cyc = 0, last_st_cyc = 0, last_done_cyc = 0;
   int st_gap = 0, st_cnt = 0, done_cnt = 0;
   logic sv_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model and output monitor
   always @(negedge clk) begin
      logic [31:0] e_wr;
      logic [63:0] e_st;
      if (mm_write_en || mm_read_en)
         check("strobe_excl", 32'(mm_write_en & mm_read_en), 32'h0);
      if (mm_write_en) begin
         e_wr = 'x;
         if (exp_wr_q.size() > 0) e_wr = exp_wr_q.pop_front();
         check("wr_addr", 32'(mm_addr), 32'h0);
         check("wr_data", mm_wdata, e_wr);
         slv_reg0    = mm_wdata;
         last_wr_cyc = cyc;
         $display("[%0d] WR   addr=%02h data=%08h", cyc, mm_addr, mm_wdata);
      end
      if (mm_read_en) begin
         case (mm_addr)
            8'h00: begin mm_rdata = corrupt ? 32'h0 : slv_reg0; last_rd0_cyc = cyc; end
            8'h01: begin mm_rdata = slv_st; st_gap = cyc - last_st_cyc; last_st_cyc = cyc; st_cnt++; end
            8'h02: begin mm_rdata = slv_er; exp_st_q.push_back({slv_st, slv_er}); end
            default: mm_rdata = 32'h0;
         endcase
         $display("[%0d] RD   addr=%02h data=%08h", cyc, mm_addr, mm_rdata);
      end
      if (cfg_done) begin
         done_cnt++;
         last_done_cyc = cyc;
         $display("[%0d] DONE mismatch=%0b", cyc, cfg_mismatch);
      end
      if (status_valid) begin
         e_st = 'x;
         if (exp_st_q.size() > 0) e_st = exp_st_q.pop_front();
         check("st_chan", 32'(active_channel), 32'(e_st[33:32]));
         check("st_sig", 32'(signal_present), 32'(e_st[37:34]));
         check("st_err", error_counts, e_st[31:0]);
         check("st_pulse", 32'(sv_prev), 32'h0);
         $display("[%0d] STAT ch=%0d sig=%h err=%08h", cyc, active_channel, signal_present, error_counts);
      end
      sv_prev = status_valid;
   end

   // Called at posedge+1; drives one cfg cycle and returns at the next posedge+1.
   task automatic send_word(input logic [31:0] w, output int t);
      cfg_valid = 1'b1;
      cfg_data  = w;
      t = cyc;
      if (cfg_ready) exp_wr_q.push_back(w);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      for (int i = 0; i < 30; i++) begin
         if (done_cnt > d0) break;
         @(posedge clk); #1;
      end
      check(tag, 32'(done_cnt > d0), 32'h1);
   endtask

   task automatic wait_rb_req(input string tag);
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mm_read_en && mm_addr == 8'h00) begin seen = 1; break; end
      end
      check(tag, 32'(seen), 32'h1);
   endtask

   initial begin
      int t0, t1, d0, s0, acc;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; poll_period = '0;
      poll_now = 1'b0; err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(cfg_ready), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_strobes", 32'({mm_write_en, mm_read_en}), 32'h0);
      check("rst_flags", 32'({cfg_done, cfg_mismatch, status_valid}), 32'h0);
      check("rst_errcnt", error_counts, 32'h0);
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // Single write latency
      d0 = done_cnt;
      send_word(32'h000FA5B1, t0);
      wait_done(d0, "single_done_timeout");
      check("lat_wr", 32'(last_wr_cyc - t0), 32'd2);
      check("lat_rb", 32'(last_rd0_cyc - t0), 32'd3);
      check("lat_done", 32'(last_done_cyc - t0), 32'd5);
      check("single_mismatch", 32'(cfg_mismatch), 32'h0);

      // Mismatch is sticky until err_clr
      corrupt = 1'b1;
      d0 = done_cnt;
      send_word(32'h12345678, t0);
      wait_done(d0, "mm_done_timeout");
      check("mm_set", 32'(cfg_mismatch), 32'h1);
      repeat (3) begin @(posedge clk); #1; end
      check("mm_sticky", 32'(cfg_mismatch), 32'h1);
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      check("mm_clear", 32'(cfg_mismatch), 32'h0);

      // err_clr coinciding with a new mismatch: set wins
      send_word(32'h0F0F0F0F, t0);
      wait_rb_req("clr_rb_timeout");
      @(posedge clk); #1; err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0;
      check("mm_set_wins", 32'(cfg_mismatch), 32'h1);
      err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
      corrupt = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // FIFO full while a poll keeps the FSM busy
      slv_st = 32'h00000036; slv_er = 32'h04030201;
      poll_now = 1'b1; @(posedge clk); #1; poll_now = 1'b0;
      @(posedge clk); #1;
      d0 = done_cnt; acc = 0;
      for (int k = 0; k < 5; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = 32'hC0DE0000 + 32'(k);
         if (k == 4) check("full_ready", 32'(cfg_ready), 32'h0);
         if (cfg_ready) begin exp_wr_q.push_back(cfg_data); acc++; end
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      check("full_accepted", 32'(acc), 32'd4);
      for (int i = 0; i < 60 && done_cnt < d0 + 4; i++) begin @(posedge clk); #1; end
      check("full_writes", 32'(done_cnt - d0), 32'd4);
      check("full_q_empty", 32'(exp_wr_q.size()), 32'h0);

      // Auto-poll every 10 cycles
      repeat (5) begin @(posedge clk); #1; end
      poll_period = 20'd10;
      for (int n = 0; n < 3; n++) begin
         s0 = st_cnt;
         for (int i = 0; i < 30 && st_cnt == s0; i++) begin @(posedge clk); #1; end
         check("poll_seen", 32'(st_cnt - s0), 32'h1);
         if (n > 0) check("poll_gap", 32'(st_gap), 32'd10);
      end
      repeat (5) begin @(posedge clk); #1; end
      check("poll_chan", 32'(active_channel), 32'd2);
      check("poll_sig", 32'(signal_present), 32'hD);
      check("poll_err", error_counts, 32'h04030201);
      poll_period = 20'd0;
      repeat (15) begin @(posedge clk); #1; end

      // Poll request together with a config word: write goes first
      slv_st = 32'h00000009; slv_er = 32'hA1B2C3D4;
      s0 = st_cnt; d0 = done_cnt;
      poll_now = 1'b1;
      send_word(32'h5A5A0001, t0);
      poll_now = 1'b0;
      for (int i = 0; i < 20 && st_cnt == s0; i++) begin @(posedge clk); #1; end
      check("prio_done", 32'(last_done_cyc - t0), 32'd5);
      check("prio_poll", 32'(last_st_cyc - t0), 32'd6);
      repeat (8) begin @(posedge clk); #1; end

      // Reset in the middle of a readback
      d0 = done_cnt;
      send_word(32'h11111111, t0);
      send_word(32'h22222222, t1);
      wait_rb_req("rst_rb_timeout");
      rst_n = 1'b0;
      #1;
      check("arst_read_en", 32'(mm_read_en), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_ready", 32'(cfg_ready), 32'h1);
      check("arst_errcnt", error_counts, 32'h0);
      exp_wr_q.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      check("arst_no_done", 32'(done_cnt), 32'(d0));
      check("end_wr_q", 32'(exp_wr_q.size()), 32'h0);
      check("end_st_q", 32'(exp_st_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
